cache_tag_lookup_ctrl: RTL and testbench

// Sequences one lookup at a time through the set-associative reference-cache tag array.

---
 rtl/cache_tag_lookup_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cache_tag_lookup_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_lookup_ctrl.sv
// Lookup sequencer for a set-associative tag array held in an external 1-cycle-read RAM.
// Owns per-set valid bits and tree pseudo-LRU state; services misses through the fill engine.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a request; applies any pending invalidate
// TAG_RD    | tag RAM read of the latched set
// COMPARE   | tag compare across all ways; hit -> RESP, miss -> victim
// MISS_REQ  | line-fill request held until the fill engine accepts
// MISS_WAIT | waiting for the fill engine to finish the line
// UPDATE    | tag rewrite, valid bit set, PLRU touched
// RESP      | result held until consumed
module cache_tag_lookup_ctrl #(
    parameter int C_N_WAY       = 3,
    parameter int TAG_ADDR_WDTH = 12,
    parameter int SET_ADDR_WDTH = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic [TAG_ADDR_WDTH-1:0]                req_tag,
    input  logic [SET_ADDR_WDTH-1:0]                req_set,
    input  logic                                    inv_all,
    output logic                                    tag_rd_en,
    output logic [SET_ADDR_WDTH-1:0]                tag_rd_addr,
    input  logic [(1<<C_N_WAY)*TAG_ADDR_WDTH-1:0]   tag_rd_data,
    output logic                                    tag_wr_en,
    output logic [SET_ADDR_WDTH-1:0]                tag_wr_addr,
    output logic [C_N_WAY-1:0]                      tag_wr_way,
    output logic [TAG_ADDR_WDTH-1:0]                tag_wr_data,
    output logic                                    fill_req_valid,
    input  logic                                    fill_req_ready,
    output logic [TAG_ADDR_WDTH-1:0]                fill_tag,
    output logic [SET_ADDR_WDTH-1:0]                fill_set,
    output logic [C_N_WAY-1:0]                      fill_way,
    input  logic                                    fill_done,
    output logic                                    resp_valid,
    input  logic                                    resp_ready,
    output logic                                    resp_hit,
    output logic [C_N_WAY-1:0]                      resp_way
);
    localparam int NUM_WAY = 1 << C_N_WAY;
    localparam int NUM_SET = 1 << SET_ADDR_WDTH;

    typedef enum logic [2:0] {
        IDLE, TAG_RD, COMPARE, MISS_REQ, MISS_WAIT, UPDATE, RESP
    } state_t;

    state_t                              state_q, state_d;
    logic [TAG_ADDR_WDTH-1:0]            tag_q;
    logic [SET_ADDR_WDTH-1:0]            set_q;
    logic [C_N_WAY-1:0]                  way_q;
    logic                                hit_q;
    logic                                inv_pend_q;
    logic [NUM_SET-1:0][NUM_WAY-1:0]     valid_q;
    logic [NUM_SET-1:0][NUM_WAY-2:0]     plru_q;

    logic                                accept;
    logic                                inv_now;
    logic [NUM_WAY-1:0]                  set_valid;
    logic                                cmp_hit;
    logic [C_N_WAY-1:0]                  hit_way;
    logic                                free_found;
    logic [C_N_WAY-1:0]                  free_way;
    logic [C_N_WAY-1:0]                  victim_way;

    // Tree nodes are heap-ordered: children of node n are 2n+1 (lower) and 2n+2 (upper).
    function automatic logic [C_N_WAY-1:0] plru_victim(input logic [NUM_WAY-2:0] tree);
        int                 node;
        logic [C_N_WAY-1:0] way;
        node = 0;
        way  = '0;
        for (int lvl = 0; lvl < C_N_WAY; lvl++) begin
            way[C_N_WAY-1-lvl] = tree[node];
            node = 2 * node + 1 + (tree[node] ? 1 : 0);
        end
        return way;
    endfunction

    function automatic logic [NUM_WAY-2:0] plru_touch(input logic [NUM_WAY-2:0] tree,
                                                      input logic [C_N_WAY-1:0] way);
        logic [NUM_WAY-2:0] t;
        int                 node;
        logic               b;
        t    = tree;
        node = 0;
        for (int lvl = 0; lvl < C_N_WAY; lvl++) begin
            b       = way[C_N_WAY-1-lvl];
            t[node] = ~b;
            node    = 2 * node + 1 + (b ? 1 : 0);
        end
        return t;
    endfunction

    assign set_valid = valid_q[set_q];
    assign accept    = req_valid && req_ready;
    assign inv_now   = (state_q == IDLE) && (inv_all || inv_pend_q);

    // Descending scan so the lowest matching / lowest free way wins.
    always_comb begin
        cmp_hit    = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = NUM_WAY - 1; w >= 0; w--) begin
            if (set_valid[w] && (tag_rd_data[w*TAG_ADDR_WDTH +: TAG_ADDR_WDTH] == tag_q)) begin
                cmp_hit = 1'b1;
                hit_way = C_N_WAY'(w);
            end
            if (!set_valid[w]) begin
                free_found = 1'b1;
                free_way   = C_N_WAY'(w);
            end
        end
        victim_way = free_found ? free_way : plru_victim(plru_q[set_q]);
    end

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        tag_rd_en      = 1'b0;
        fill_req_valid = 1'b0;
        tag_wr_en      = 1'b0;
        resp_valid     = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !inv_pend_q;
                if (req_valid && !inv_pend_q) state_d = TAG_RD;
            end
            TAG_RD: begin
                tag_rd_en = 1'b1;
                state_d   = COMPARE;
            end
            COMPARE:   state_d = cmp_hit ? RESP : MISS_REQ;
            MISS_REQ: begin
                fill_req_valid = 1'b1;
                if (fill_req_ready) state_d = MISS_WAIT;
            end
            MISS_WAIT: if (fill_done) state_d = UPDATE;
            UPDATE: begin
                tag_wr_en = 1'b1;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = IDLE;
            end
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            set_q      <= '0;
            way_q      <= '0;
            hit_q      <= 1'b0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
            plru_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                tag_q <= req_tag;
                set_q <= req_set;
            end
            if (state_q == COMPARE) begin
                hit_q <= cmp_hit;
                way_q <= cmp_hit ? hit_way : victim_way;
                if (cmp_hit) plru_q[set_q] <= plru_touch(plru_q[set_q], hit_way);
            end
            if (state_q == UPDATE) begin
                valid_q[set_q][way_q] <= 1'b1;
                plru_q[set_q]         <= plru_touch(plru_q[set_q], way_q);
            end
            // Invalidate only ever fires in IDLE, so it never races the UPDATE write.
            if (inv_now) begin
                valid_q    <= '0;
                inv_pend_q <= 1'b0;
            end else if (inv_all) begin
                inv_pend_q <= 1'b1;
            end
        end
    end

    assign tag_rd_addr = tag_rd_en ? set_q : '0;
    assign tag_wr_addr = tag_wr_en ? set_q : '0;
    assign tag_wr_way  = tag_wr_en ? way_q : '0;
    assign tag_wr_data = tag_wr_en ? tag_q : '0;
    assign fill_tag    = fill_req_valid ? tag_q : '0;
    assign fill_set    = fill_req_valid ? set_q : '0;
    assign fill_way    = fill_req_valid ? way_q : '0;
    assign resp_hit    = resp_valid && hit_q;
    assign resp_way    = resp_valid ? way_q : '0;

endmodule

// File: tb/tb_cache_tag_lookup_ctrl.sv
// Self-checking bench for cache_tag_lookup_ctrl: directed vector table, hand-written corner
// sequences and randomized lookups against a range-based set/way/PLRU reference model.
module tb_cache_tag_lookup_ctrl;
    localparam int TW = 12;
    localparam int SW = 5;
    localparam int WW = 3;
    localparam int NW = 8;
    localparam int NS = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [TW-1:0]     req_tag = '0;
    logic [SW-1:0]     req_set = '0;
    logic              inv_all = 1'b0;
    logic              tag_rd_en;
    logic [SW-1:0]     tag_rd_addr;
    logic [NW*TW-1:0]  tag_rd_data;
    logic              tag_wr_en;
    logic [SW-1:0]     tag_wr_addr;
    logic [WW-1:0]     tag_wr_way;
    logic [TW-1:0]     tag_wr_data;
    logic              fill_req_valid;
    logic              fill_req_ready = 1'b0;
    logic [TW-1:0]     fill_tag;
    logic [SW-1:0]     fill_set;
    logic [WW-1:0]     fill_way;
    logic              fill_done = 1'b0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_hit;
    logic [WW-1:0]     resp_way;

    int checks = 0;
    int errors = 0;

    cache_tag_lookup_ctrl #(.C_N_WAY(WW), .TAG_ADDR_WDTH(TW), .SET_ADDR_WDTH(SW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag), .req_set(req_set),
        .inv_all(inv_all),
        .tag_rd_en(tag_rd_en), .tag_rd_addr(tag_rd_addr), .tag_rd_data(tag_rd_data),
        .tag_wr_en(tag_wr_en), .tag_wr_addr(tag_wr_addr), .tag_wr_way(tag_wr_way),
        .tag_wr_data(tag_wr_data),
        .fill_req_valid(fill_req_valid), .fill_req_ready(fill_req_ready),
        .fill_tag(fill_tag), .fill_set(fill_set), .fill_way(fill_way), .fill_done(fill_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way)
    );

    always #5 clk = ~clk;

    // Tag RAM: 1-cycle read, single-way write; poke port lets the bench plant duplicate tags.
    logic [TW-1:0] mem [NS][NW];
    logic          poke_en = 1'b0;
    int            poke_set = 0;
    int            poke_way = 0;
    logic [TW-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (tag_rd_en)
            for (int w = 0; w < NW; w++) tag_rd_data[w*TW +: TW] <= mem[tag_rd_addr][w];
        if (tag_wr_en) mem[tag_wr_addr][tag_wr_way] <= tag_wr_data;
        if (poke_en) mem[poke_set][poke_way] <= poke_data;
    end

    // Reference model
    bit            m_valid [NS][NW];
    logic [TW-1:0] m_tag   [NS][NW];
    bit            m_tree  [NS][NW-1];

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) begin
            for (int w = 0; w < NW; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
            end
            for (int n = 0; n < NW - 1; n++) m_tree[s][n] = 1'b0;
        end
    endfunction

    function automatic void m_inv();
        for (int s = 0; s < NS; s++)
            for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
    endfunction

    function automatic int m_pick(input int s);
        int lo, size, node, pick;
        pick = -1;
        for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) pick = w;
        if (pick >= 0) return pick;
        lo = 0; size = NW; node = 0;
        while (size > 1) begin
            size = size / 2;
            if (m_tree[s][node]) begin lo = lo + size; node = 2 * node + 2; end
            else node = 2 * node + 1;
        end
        return lo;
    endfunction

    function automatic void m_touch(input int s, input int way);
        int lo, size, node;
        lo = 0; size = NW; node = 0;
        while (size > 1) begin
            size = size / 2;
            if (way >= lo + size) begin
                m_tree[s][node] = 1'b0;
                lo = lo + size;
                node = 2 * node + 2;
            end else begin
                m_tree[s][node] = 1'b1;
                node = 2 * node + 1;
            end
        end
    endfunction

    function automatic void m_lookup(input int s, input logic [TW-1:0] t,
                                     output bit hit, output int way);
        hit = 1'b0;
        way = 0;
        for (int w = NW - 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == t) begin hit = 1'b1; way = w; end
        if (!hit) begin
            way = m_pick(s);
            m_valid[s][way] = 1'b1;
            m_tag[s][way]   = t;
        end
        m_touch(s, way);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] quiet_outs();
        return {11'd0, tag_rd_en, tag_rd_addr, tag_wr_en, tag_wr_addr, tag_wr_way, tag_wr_data,
                fill_req_valid, fill_tag, fill_set, fill_way, resp_valid, resp_hit, resp_way};
    endfunction

    // Drives one lookup from a negedge and returns at the negedge where the DUT is back in IDLE.
    task automatic lookup(input int s, input logic [TW-1:0] t, input int rdy_wait,
                          input int done_wait, input int resp_wait, input bit inv_mid,
                          output bit hit, output int way, output int lat);
        int k, fw, dw, rw, writes, fill_hs;
        bit fill_acc, done_sent, seen_resp, finished, inv_sent, fway_set;
        logic [WW-1:0] fway, rway0;
        logic rhit0;
        k = 0; fw = 0; dw = 0; rw = 0; writes = 0; fill_hs = 0;
        fill_acc = 0; done_sent = 0; seen_resp = 0; finished = 0; inv_sent = 0; fway_set = 0;
        fway = '0; rway0 = '0; rhit0 = 1'b0; lat = 0;
        req_set = SW'(s); req_tag = t; req_valid = 1'b1;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        if (!req_ready) check("req_accept_timeout", 0, 1);
        @(negedge clk);
        req_valid = 1'b0;
        k = 1;
        while (!finished && k < 400) begin
            fill_done = 1'b0;
            inv_all   = 1'b0;
            if (fill_req_ready) fill_req_ready = 1'b0;
            if (tag_wr_en) begin
                writes++;
                check("tag_wr_addr", tag_wr_addr, SW'(s));
                check("tag_wr_data", tag_wr_data, t);
                check("tag_wr_way", tag_wr_way, fway);
            end
            if (fill_req_valid) begin
                if (!fway_set) begin fway = fill_way; fway_set = 1; end
                check("fill_set", fill_set, SW'(s));
                check("fill_tag", fill_tag, t);
                check("fill_way_stable", fill_way, fway);
                if (fw < rdy_wait) fw++;
                else begin fill_req_ready = 1'b1; fill_acc = 1; fill_hs++; end
            end else if (fill_acc && !done_sent) begin
                if (inv_mid && !inv_sent) begin inv_all = 1'b1; inv_sent = 1; end
                if (dw < done_wait) dw++;
                else begin fill_done = 1'b1; done_sent = 1; end
            end
            if (resp_valid) begin
                if (!seen_resp) begin
                    seen_resp = 1; lat = k; rhit0 = resp_hit; rway0 = resp_way;
                end else begin
                    check("resp_hit_stable", resp_hit, rhit0);
                    check("resp_way_stable", resp_way, rway0);
                end
                if (rw < resp_wait) rw++;
                else resp_ready = 1'b1;
            end else if (resp_ready) begin
                resp_ready = 1'b0;
                finished = 1;
            end
            if (!finished) begin @(negedge clk); k++; end
        end
        if (!finished) check("lookup_timeout", 0, 1);
        fill_req_ready = 1'b0; fill_done = 1'b0; resp_ready = 1'b0; inv_all = 1'b0;
        hit = rhit0;
        way = int'(rway0);
        check("tag_wr_count", writes, rhit0 ? 0 : 1);
        check("fill_hs_count", fill_hs, rhit0 ? 0 : 1);
        if (!rhit0) check("fill_way_vs_resp_way", fway, rway0);
    endtask

    task automatic run_one(input string name, input int s, input logic [TW-1:0] t,
                           input int r, input int d, input int p, input bit inv_mid,
                           input bit exp_hit, input int exp_way);
        bit hit;
        int way, lat;
        lookup(s, t, r, d, p, inv_mid, hit, way, lat);
        check({name, "_hit"}, hit, exp_hit);
        check({name, "_way"}, way, exp_way);
        check({name, "_lat"}, lat, exp_hit ? 3 : 6 + r + d);
    endtask

    task automatic idle_inv();
        inv_all = 1'b1;
        @(negedge clk);
        inv_all = 1'b0;
        m_inv();
        check("idle_inv_no_pend_ready", req_ready, 1);
    endtask

    typedef struct {
        int            s;
        logic [TW-1:0] t;
        bit            hit;
        int            way;
    } vec_t;

    vec_t vecs [15];

    initial begin
        bit eh;
        int ew, s, r, d, p;
        logic [TW-1:0] t;

        vecs[0]  = '{3, 12'h0AB, 1'b0, 0};
        vecs[1]  = '{3, 12'h0AB, 1'b1, 0};
        vecs[2]  = '{5, 12'h100, 1'b0, 0};
        vecs[3]  = '{5, 12'h101, 1'b0, 1};
        vecs[4]  = '{5, 12'h102, 1'b0, 2};
        vecs[5]  = '{5, 12'h103, 1'b0, 3};
        vecs[6]  = '{5, 12'h104, 1'b0, 4};
        vecs[7]  = '{5, 12'h105, 1'b0, 5};
        vecs[8]  = '{5, 12'h106, 1'b0, 6};
        vecs[9]  = '{5, 12'h107, 1'b0, 7};
        vecs[10] = '{5, 12'h100, 1'b1, 0};
        vecs[11] = '{5, 12'h108, 1'b0, 4};
        vecs[12] = '{5, 12'h108, 1'b1, 4};
        vecs[13] = '{5, 12'h107, 1'b1, 7};
        vecs[14] = '{3, 12'h0AC, 1'b0, 1};

        m_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        check("reset_outputs_zero", quiet_outs(), 64'd0);
        check("reset_req_ready", req_ready, 1);

        for (int i = 0; i < 15; i++) begin
            m_lookup(vecs[i].s, vecs[i].t, eh, ew);
            run_one("vec", vecs[i].s, vecs[i].t, 0, 0, 0, 1'b0, vecs[i].hit, vecs[i].way);
        end

        // Duplicate valid tag in way 3: lowest way must win.
        poke_set = 5; poke_way = 3; poke_data = 12'h100; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
        m_lookup(5, 12'h100, eh, ew);
        run_one("multi_hit", 5, 12'h100, 0, 0, 0, 1'b0, 1'b1, 0);
        poke_data = m_tag[5][3]; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;

        // Long fill-accept and response stalls on a full set.
        m_lookup(5, 12'h109, eh, ew);
        run_one("stall", 5, 12'h109, 10, 2, 5, 1'b0, eh, ew);

        // Invalidate during MISS_WAIT: original miss result, then ready low one cycle.
        m_lookup(3, 12'h0AD, eh, ew);
        run_one("inv_mid", 3, 12'h0AD, 0, 1, 0, 1'b1, 1'b0, 2);
        m_inv();
        check("inv_pend_ready_low", req_ready, 0);
        @(negedge clk);
        check("inv_pend_ready_back", req_ready, 1);
        m_lookup(3, 12'h0AB, eh, ew);
        run_one("after_inv", 3, 12'h0AB, 0, 0, 0, 1'b0, 1'b0, 0);

        // Reset during MISS_WAIT; late fill_done must be ignored.
        req_set = 5'd3; req_tag = 12'h0EE; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 10 && !fill_req_valid; i++) @(negedge clk);
        check("rst_seq_fill_req", fill_req_valid, 1);
        fill_req_ready = 1'b1;
        @(negedge clk);
        fill_req_ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_mid_outputs_zero", quiet_outs(), 64'd0);
        check("rst_mid_req_ready", req_ready, 1);
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        check("late_done_ignored", quiet_outs(), 64'd0);
        check("late_done_req_ready", req_ready, 1);
        m_reset();
        m_lookup(3, 12'h0AB, eh, ew);
        run_one("after_rst", 3, 12'h0AB, 0, 0, 0, 1'b0, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 19) == 0) idle_inv();
            s = 8 + int'($urandom_range(0, 3));
            t = 12'h200 + 12'($urandom_range(0, 11));
            r = int'($urandom_range(0, 3));
            d = int'($urandom_range(0, 3));
            p = int'($urandom_range(0, 3));
            m_lookup(s, t, eh, ew);
            run_one("rand", s, t, r, d, p, 1'b0, eh, ew);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
